fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 105 ++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pops words from an upstream FIFO with a one-cycle read
// latency and presents them on a valid/ready output stream. A two-entry
// in-order buffer plus an in-flight flag keep one word per cycle flowing
// without ever popping a word that has nowhere to land.
//
// Handshake: a word moves downstream on a rising clk edge where m_valid and
// m_ready are both high; while m_valid is high and m_ready low, m_valid and
// m_data hold steady. Upstream, fifo_read high in cycle N pops a word whose
// data is presented on fifo_read_data in cycle N+1.
module fifo_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_read_data,
  output logic                   fifo_read,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            occ;        // buffered words, 0..2
  logic                  inflight;   // a popped word arrives this cycle
  logic [DATA_WIDTH-1:0] buf_head;   // oldest buffered word, drives m_data
  logic [DATA_WIDTH-1:0] buf_tail;   // second buffered word
  logic                  handshake;
  logic [2:0]            level_after;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = buf_head;
  assign handshake = m_valid & m_ready;
  assign busy      = m_valid | inflight;

  // Slots still claimed after this cycle's retirement; a handshake implies
  // occ >= 1, so the subtraction cannot underflow.
  assign level_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, handshake};

  // Pop only when the word will have a free slot on arrival. reset_n gates
  // the request so it drops together with the asynchronously cleared state.
  assign fifo_read = reset_n & enable & ~fifo_empty & ~flush &
                     (level_after < 3'd2);

  // Occupancy and in-flight tracking; flush empties both, dropping any word
  // that arrives from a pop issued before the flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else if (flush) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read;
      case ({inflight, handshake})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage: retire shifts tail into head, capture writes the first
  // free slot after the shift so order is preserved on simultaneous events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_head <= '0;
      buf_tail <= '0;
    end else if (!flush) begin
      if (handshake) begin
        if (inflight && occ == 2'd1) begin
          buf_head <= fifo_read_data;
        end else begin
          buf_head <= buf_tail;
        end
        if (inflight && occ == 2'd2) begin
          buf_tail <= fifo_read_data;
        end
      end else if (inflight) begin
        if (occ == 2'd0) begin
          buf_head <= fifo_read_data;
        end else begin
          buf_tail <= fifo_read_data;
        end
      end
    end
  end

  // Delivered-word counter; wraps naturally and survives flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
    end else if (handshake) begin
      word_count <= word_count + COUNT_ONE;
    end
  end

endmodule
